// File: rtl/mips_cpu_hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_cpu_pkg;
  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;
endpackage

// File: rtl/mips_cpu_hilo_muldiv_if.sv
// Execute-stage bus between pipeline control and the multiply/divide unit.
interface mips_cpu_hilo_muldiv_if;
  import mips_cpu_pkg::*;
  logic                    start;
  muldiv_op_t              op;
  logic [MULDIV_WIDTH-1:0] a, b, wdata;
  logic                    mthi, mtlo;
  logic                    busy, done;
  logic [MULDIV_WIDTH-1:0] hi, lo;

  modport master (output start, op, a, b, mthi, mtlo, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mips_cpu_muldiv_step
  import mips_cpu_pkg::*;
(
  input  logic                      is_div_i,
  input  logic [2*MULDIV_WIDTH-1:0] acc_i,
  input  logic [MULDIV_WIDTH-1:0]   m_i,
  output logic [2*MULDIV_WIDTH-1:0] acc_o
);
  localparam int W = MULDIV_WIDTH;

  logic [W:0] sum, rem_sh, diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*W-1:W]} + {1'b0, m_i};
    rem_sh = {acc_i[2*W-1:W], acc_i[W-1]};
    diff   = rem_sh - {1'b0, m_i};
    if (is_div_i) begin
      // diff[W] is the borrow: partial remainder smaller than divisor, keep it
      if (diff[W]) acc_o = {acc_i[2*W-2:0], 1'b0};
      else         acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
    end else begin
      if (acc_i[0]) acc_o = {sum, acc_i[W-1:1]};
      else          acc_o = {1'b0, acc_i[2*W-1:1]};
    end
  end
endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO.
// MIPS_CPU_MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module mips_cpu_hilo_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_cpu_hilo_muldiv_if.slave  bus
);
  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sa_q, sa_d, sb_q, sb_d, done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
  logic [WIDTH-1:0]   ma_in, mb_in, quo, rem;
  logic               sgn_in, is_div;

  assign sgn_in = (bus.op == MD_MULT) || (bus.op == MD_DIV);
  assign ma_in  = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mb_in  = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // Sign flags are only set for signed ops, so unsigned ops skip fixup naturally.
  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  mips_cpu_muldiv_step u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .m_i      (is_div ? mb_q : ma_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          sa_d    = sgn_in & bus.a[WIDTH-1];
          sb_d    = sgn_in & bus.b[WIDTH-1];
          ma_d    = ma_in;
          mb_d    = mb_in;
          a_d     = bus.a;
          cnt_d   = '0;
          // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
          acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, ma_in} : {{WIDTH{1'b0}}, mb_in};
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_ITERS - 1)) state_d = FIXUP;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
        if (!is_div) begin
          acc_d   = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
          state_d = FIXUP;
        end
`endif
      end
      FIXUP: begin
        if (!is_div) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (mb_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Randomized bench for the HI/LO multiply/divide unit against an arithmetic model.
module tb_mips_cpu_hilo_muldiv;
  import mips_cpu_pkg::*;

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_hilo_muldiv_if bus ();
  mips_cpu_hilo_muldiv dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: cycles left until the result lands, pending result, visible HI/LO.
  int          m_rem;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_done;

  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, b,
                                 output logic [31:0] hi, lo);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    case (op)
      2'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'd2: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'd0; lo = 32'h8000_0000; end
        else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          hi = sr; lo = sq;
        end
      end
      default: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(bus.busy), 32'(m_rem > 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
    end else begin
      if (bus.mthi) m_hi = bus.wdata;
      if (bus.mtlo) m_lo = bus.wdata;
      if (bus.start) begin
        ref_op(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_rem = bus.op[1] ? DIV_LAT : MUL_LAT;
      end
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.op = MD_MULT; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
  endtask

  // Check what the last edge produced, then drive inputs for the next edge.
  task automatic tick(input bit st, input logic [1:0] o, input logic [31:0] ia, ib,
                      input bit mh, ml, input logic [31:0] wd);
    @(negedge clk);
    check_outputs();
    bus.start = st; bus.op = muldiv_op_t'(o); bus.a = ia; bus.b = ib;
    bus.mthi = mh; bus.mtlo = ml; bus.wdata = wd;
    model_step();
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] ia, ib,
                        input logic [31:0] ehi, elo);
    tick(1'b1, o, ia, ib, 1'b0, 1'b0, '0);
    repeat (o[1] ? DIV_LAT : MUL_LAT) idle();
    idle();
    chk({nm, "_done"}, 32'(bus.done), 32'd1);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    tick(1'b0, 2'd0, '0, '0, 1'b1, 1'b0, 32'h1234);
    idle();
    chk("mthi_idle", bus.hi, 32'h1234);

    // MTHI/MTLO and a second start while busy must all be ignored.
    tick(1'b1, 2'd0, 32'd5, 32'd6, 1'b0, 1'b0, '0);
    repeat (MUL_LAT) tick(1'b1, 2'd3, 32'd99, 32'd3, 1'b1, 1'b1, 32'hDEAD_BEEF);
    idle();
    chk("busy_ign_hi", bus.hi, 32'd0);
    chk("busy_ign_lo", bus.lo, 32'd30);
    idle();
    chk("busy_ign_idle", 32'(bus.busy), 32'd0);

    // New start accepted in the done cycle.
    tick(1'b1, 2'd1, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    repeat (MUL_LAT) idle();
    tick(1'b1, 2'd3, 32'd30, 32'd6, 1'b0, 1'b0, '0);
    repeat (DIV_LAT) idle();
    idle();
    chk("b2b_lo", bus.lo, 32'd5);
    chk("b2b_hi", bus.hi, 32'd0);

    // Reset mid-operation.
    tick(1'b1, 2'd0, 32'd1234, 32'd5678, 1'b0, 1'b0, '0);
    repeat (10) idle();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    drive_idle();
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post_rst_mult", 2'd0, 32'd5, 32'd6, 32'd0, 32'd30);

    for (int i = 0; i < 6000; i++)
      tick(($urandom % 4) == 0, 2'($urandom % 4), pick(), pick(),
           ($urandom % 5) == 0, ($urandom % 5) == 0, $urandom);
    repeat (DIV_LAT + 2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
